serial_code_receiver: RTL and testbench
=======================================

// Module: serial_code_receiver
// PURPOSE
//   Receive-side deframer for the transceiver link. Samples the serial line driven by the
//   transmitter's GPIO_1[17] output and recovers each 8-bit button code.
//   Presents the recovered code with a one-cycle valid strobe.
//   Flags framing errors. Sits directly downstream of the TX shifter, at the RX board's GPIO input.
// PARAMETERS
//   CLKS_PER_BIT  12500  CLOCK_50 cycles per line bit (50 MHz / 4 kHz); must be even and >= 4
//   DATA_BITS     8      payload width, sent MSB first
//   SYNC_STAGES   2      flip-flops in the input synchronizer (>= 2)
// PORTS
//   CLOCK_50    in   1          50 MHz system clock; the only clock
//   RESET_N     in   1          asynchronous, active-low reset
//   rx_in       in   1          raw serial line from GPIO (asynchronous to CLOCK_50)
//   code        out  DATA_BITS  last correctly received code
//   code_valid  out  1          one-cycle pulse: code was updated this cycle
//   frame_err   out  1          one-cycle pulse: frame rejected (bad stop bit or parity)
//   busy        out  1          high while the receiver is not in IDLE
// BEHAVIOUR
//   Reset: code=0, code_valid=0, frame_err=0, busy=0, FSM=IDLE.
//     Counters and synchronizer clear to 0. Async assert; deassert takes effect on the next clock edge.
//     Reset mid-frame discards the partial frame. No output pulse is generated.
//   Frame: idle line = 0. Start bit = 1. DATA_BITS data bits, MSB first. [parity]. Stop bit = 0.
//   rx_in passes through SYNC_STAGES flops. All decisions use the synchronized value rx_s.
//   FSM:
//     IDLE  : a 0->1 edge on rx_s -> START. Load bit_cnt=0 and timer=CLKS_PER_BIT/2-1.
//     START : at timer==0, resample. rx_s==1 -> DATA with timer=CLKS_PER_BIT-1.
//             rx_s==0 -> glitch: return to IDLE silently, with no pulse.
//     DATA  : at timer==0, shift rx_s into shift_reg LSB (first bit lands in MSB after DATA_BITS shifts).
//             Then increment bit_cnt and reload the timer.
//             After bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
//     PARITY: at timer==0, sample the parity bit and reload the timer -> STOP.
//     STOP  : at timer==0, sample.
//             rx_s==0 and parity ok -> code<=shift_reg, code_valid=1 for exactly one cycle.
//             Otherwise frame_err=1 for one cycle and code is unchanged.
//             Next state is IDLE either way.
//   Timer is a down-counter of width $clog2(CLKS_PER_BIT). Bit samples fall at the bit centre.
//   Latency: code_valid asserts on the clock after the stop-bit centre sample.
//     Measured from the synchronized start edge: (DATA_BITS+1[+1])*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles.
//   code_valid and frame_err are never high together.
//   Back-to-back frames: after STOP the FSM is in IDLE within 1 cycle.
//     A new start edge is accepted from that cycle onward.
//     If the line is still 1 at the stop sample (framing error), no new frame starts until rx_s returns to 0.
//   busy = (state != IDLE).
// CONFIGURATION
//   RX_PARITY_EN defined   : the frame carries an even-parity bit after the data.
//                            Parity mismatch -> frame_err, code held. FSM includes PARITY.
//   RX_PARITY_EN undefined : there is no parity bit. The PARITY state and XOR logic are absent.
//                            Frame length = DATA_BITS+2 bits.
//   The matching TX shifter must be built with the same setting.
// STRUCTURE
//   Package cwru_link_pkg:
//     FSM state encoding: IDLE, START, DATA, PARITY, STOP.
//     Constants: LINE_IDLE=0, START_BIT=1, STOP_BIT=0, default CLKS_PER_BIT=12500.
//     Shared with the TX shifter.
//   Sub-module rx_bit_timer: reloadable down-counter that provides a half-period load,
//     a full-period load and a tick-at-zero output.
//   Synchronizer, FSM and shift register stay in this module.
// TESTING  (bench uses CLKS_PER_BIT=16, DATA_BITS=8)
//   1. Reset, then send frame 0xA5, then idle 0
//      -> one code_valid pulse, code=0xA5, frame_err stays 0, busy falls in the same cycle.
//   2. Pulse rx_in high for 4 cycles (shorter than half a bit)
//      -> FSM returns to IDLE, no pulse, code unchanged.
//   3. Send 0x3C with the stop bit forced to 1
//      -> frame_err pulse, code keeps its prior value (0xA5), no code_valid.
//   4. Send 0x01 then 0xFE back-to-back with zero idle bits
//      -> two code_valid pulses, 10*16 cycles apart; code=0x01, then 0xFE.
//   5. Assert RESET_N low in the middle of data bit 4 of 0x77
//      -> all outputs 0 immediately, no pulse after release; the next clean 0x77 is received correctly.
//   6. RX_PARITY_EN: send 0x81 with correct even parity -> code_valid.
//      Send it with the parity bit flipped -> frame_err, code unchanged.

Source files
------------

// File: rtl/cwru_link_pkg.sv
// Shared definitions for the transceiver link: FSM states and line levels.
// Used by both the TX shifter and the receive deframer.
package cwru_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE        = 1'b0;
    localparam logic START_BIT        = 1'b1;
    localparam logic STOP_BIT         = 1'b0;
    localparam int   DEF_CLKS_PER_BIT = 12500;

endpackage

// File: rtl/rx_bit_timer.sv
// Reloadable bit-period down-counter; tick is high while the count is zero.
// A half-period load centres the first sample inside the start bit.
module rx_bit_timer
    import cwru_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (load_half) begin
            timer <= TW'(CLKS_PER_BIT / 2 - 1);
        end else if (load_full) begin
            timer <= TW'(CLKS_PER_BIT - 1);
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    assign tick = (timer == '0);

endmodule

// File: rtl/serial_code_receiver.sv
// Serial button-code deframer: start=1, data MSB first, stop=0, idle line 0.
// Define RX_PARITY_EN to expect an even-parity bit between data and stop.
module serial_code_receiver
    import cwru_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] code,
    output logic                 code_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   rise;
    rx_state_t              state;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tick;
    logic                   load_half;
    logic                   load_full;
    logic                   par_ok;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync    <= '0;
            rx_prev <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rx_in};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];
    assign rise = (rx_s == START_BIT) && (rx_prev == LINE_IDLE);
    assign busy = (state != IDLE);

    assign load_half = (state == IDLE) && rise;
    assign load_full = tick && (
        ((state == START) && (rx_s == START_BIT)) ||
        (state == DATA) || (state == PARITY));

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (CLOCK_50),
        .rst_n    (RESET_N),
        .load_half(load_half),
        .load_full(load_full),
        .tick     (tick)
    );

`ifdef RX_PARITY_EN
    logic par_bit;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(^{shift_reg, par_bit});
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= (rx_s == START_BIT) ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {shift_reg[DATA_BITS-2:0], rx_s};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(DATA_BITS - 1)) begin
`ifdef RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
                PARITY: begin
`ifdef RX_PARITY_EN
                    if (tick) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (tick) begin
                        if ((rx_s == STOP_BIT) && par_ok) begin
                            code       <= shift_reg;
                            code_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_receiver.sv
// Randomised scoreboard bench for serial_code_receiver (CLKS_PER_BIT=16).
// Define RX_PARITY_EN for both RTL and bench to exercise the parity frame.
module tb_serial_code_receiver;

    localparam int N = 16;
`ifdef RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int FB     = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int FB     = 10;
`endif

    typedef struct {
        bit         is_err;
        logic [7:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_v = 0;
    int         prev_v = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_code;

    serial_code_receiver #(
        .CLKS_PER_BIT(N),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .rx_in     (rx_in),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected frame result.
    always @(negedge clk) begin
        exp_t e;
        if (code_valid && frame_err) begin
            total++;
            bad++;
            $display("FAIL both_pulses: code_valid and frame_err high together");
        end
        if (code_valid || frame_err) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0h",
                         code_valid, frame_err, code);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                check("pulse_code", {24'd0, code}, {24'd0, e.code});
                if (code_valid) begin
                    check("busy_at_valid", {31'd0, busy}, 32'd0);
                    prev_v = last_v;
                    last_v = cyc;
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (N) @(negedge clk);
    endtask

    // Reference: the frame is accepted iff stop is low and parity is even.
    task automatic send_frame(input logic [7:0] d, input bit bad_stop,
                              input bit bad_par, input int gap);
        exp_t e;
        logic par;
        int   g;
        par = (^d) ^ bad_par;
        e.is_err = bad_stop || (PAR_EN && bad_par);
        e.code   = e.is_err ? exp_code : d;
        exp_code = e.code;
        exp_q.push_back(e);
        g = (bad_stop && gap == 0) ? 1 : gap;
        drive_bit(1'b1);
        for (int i = 7; i >= 0; i--) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(bad_stop ? 1'b1 : 1'b0);
        repeat (g) drive_bit(1'b0);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3 * FB * N) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d pulses missing, 0 expected",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         bs;
        bit         bp;
        rst_n    = 1'b0;
        rx_in    = 1'b0;
        exp_code = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_code", {24'd0, code}, 32'd0);
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2 * N) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b0, 2);
        drain();
        check("t1_code", {24'd0, code}, 32'hA5);

        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("t2_busy_start", {31'd0, busy}, 32'd1);
        rx_in = 1'b0;
        repeat (2 * N) @(negedge clk);
        check("t2_busy_idle", {31'd0, busy}, 32'd0);
        check("t2_code", {24'd0, code}, {24'd0, exp_code});

        send_frame(8'h3C, 1'b1, 1'b0, 2);
        drain();
        check("t3_code", {24'd0, code}, 32'hA5);

        send_frame(8'h01, 1'b0, 1'b0, 0);
        send_frame(8'hFE, 1'b0, 1'b0, 1);
        drain();
        check("t4_spacing", last_v - prev_v, FB * N);
        check("t4_code", {24'd0, code}, 32'hFE);

        d = 8'h77;
        drive_bit(1'b1);
        for (int i = 7; i >= 4; i--) drive_bit(d[i]);
        rx_in = d[3];
        repeat (N / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_code", {24'd0, code}, 32'd0);
        check("t5_valid", {31'd0, code_valid}, 32'd0);
        check("t5_err", {31'd0, frame_err}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rx_in    = 1'b0;
        rst_n    = 1'b1;
        exp_code = 8'h00;
        repeat (2 * N) @(negedge clk);
        send_frame(8'h77, 1'b0, 1'b0, 1);
        drain();
        check("t5_code_after", {24'd0, code}, 32'h77);

`ifdef RX_PARITY_EN
        send_frame(8'h81, 1'b0, 1'b0, 1);
        drain();
        check("t6_good", {24'd0, code}, 32'h81);
        send_frame(8'h81, 1'b0, 1'b1, 1);
        drain();
        check("t6_bad", {24'd0, code}, 32'h81);
`endif

        for (int n = 0; n < 10; n++) begin
            d  = 8'($urandom);
            bs = ($urandom_range(0, 3) == 0);
            bp = PAR_EN && ($urandom_range(0, 3) == 0);
            send_frame(d, bs, bp, $urandom_range(0, 2));
        end
        drain();
        check("rand_code", {24'd0, code}, {24'd0, exp_code});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
